controle_multiciclo: RTL
========================

# controle_multiciclo

Multicycle control FSM for the FPGA RISC-V datapath. It sequences every instruction through fetch, decode, execute, memory, write-back and PC-update states, and broadcasts the current state on `estado`. In the PC-update state (4'b1000) it drives `pcsrc`, `immediate` and `negativo`, which the PC incrementer consumes. It also drives the register-file, ALU and memory enables.

## Interface
Parameters:
- `LARGURA_INSTR`, 32: instruction width.

Ports:
- `clk` in 1: single clock; all state changes occur on its rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `instrucao` in 32: instruction-memory output; valid during BUSCA.
- `zero` in 1: ALU equality flag (rs1 == rs2); valid during EXECUTA.
- `mem_pronto` in 1: data-memory ready handshake.
- `estado` out 4: current FSM state code.
- `pcsrc` out 1: 1 selects a branch target, 0 selects PC+1.
- `immediate` out 12: magnitude of the branch byte offset.
- `negativo` out 1: sign of the branch offset.
- `regwrite`, `memread`, `memwrite`, `alusrc`, `memtoreg` out 1 each: datapath enables.
- `aluop` out 2: 00 add, 01 subtract/compare, 10 funct-decoded.
- `ilegal` out 1: one-cycle pulse on an unsupported instruction.

## Operation
State codes:
- BUSCA 0000
- DECODIFICA 0001
- EXECUTA 0010
- MEMORIA 0011
- ESCRITA 0100
- ATUALIZA_PC 1000

Transitions:
- BUSCA→DECODIFICA. `instrucao` is latched into an internal register on this edge.
- DECODIFICA→EXECUTA for supported opcodes.
- DECODIFICA→ATUALIZA_PC for anything else. `ilegal` pulses for one cycle and the instruction is treated as a NOP with `pcsrc`=0.
- EXECUTA:
  - R-type (0110011) and I-ALU (0010011) go to ESCRITA.
  - Load (0000011) and store (0100011) go to MEMORIA.
  - Branch (1100011) goes to ATUALIZA_PC.
- MEMORIA holds while `mem_pronto`=0. When `mem_pronto`=1, a load goes to ESCRITA and a store goes to ATUALIZA_PC.
- ESCRITA→ATUALIZA_PC.
- ATUALIZA_PC→BUSCA.

Branch decision, made in EXECUTA:
- beq (funct3 000): `pcsrc` = `zero`.
- bne (funct3 001): `pcsrc` = !`zero`.
- Any other funct3 is illegal. `ilegal` pulses in EXECUTA and `pcsrc` is 0.

Immediate rules:
- The byte offset is the 13-bit signed value {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- `negativo` = bit 12 of the offset.
- `immediate` = the lower 12 bits of the offset's absolute value.
- An offset of −4096 is clamped to `immediate`=12'hFFC with `negativo`=1.
- Offsets that are not word-aligned are passed through unchanged; the consumer truncates them with /4.

Enables are active only in the state that uses them:
- `memread` in MEMORIA for loads.
- `memwrite` in MEMORIA for stores.
- `regwrite` in ESCRITA.
- `memtoreg` in ESCRITA for loads.

## Timing
- Reset values: `estado`=0000, all other outputs 0, latched instruction 0.
- If `rst` is asserted in any state, the block is in BUSCA on the next cycle. No ATUALIZA_PC is issued, so the PC is not advanced.
- `pcsrc`, `immediate` and `negativo` are registered. They are written on the EXECUTA→ATUALIZA_PC edge (or DECODIFICA→ATUALIZA_PC for illegal instructions), held stable for the whole ATUALIZA_PC cycle, and cleared on entry to BUSCA.
- Latency without memory stalls:
  - Branch: 4 cycles.
  - R-type, I-ALU and store: 5 cycles.
  - Load: 6 cycles.
  - Illegal: 3 cycles.
  - Each cycle that MEMORIA holds waiting for `mem_pronto` adds 1 cycle.
- `mem_pronto` is sampled only in MEMORIA and ignored in every other state.
- `zero` is sampled only in EXECUTA.
- `ilegal` is never asserted in consecutive cycles.

## Configuration
- `SUPORTE_BNE_EN`
  - Defined: bne is decoded as described in Operation.
  - Undefined: funct3 001 on the branch opcode is illegal (`ilegal` pulse, `pcsrc`=0). beq is unaffected.

## Structure
- Shared package `controle_pkg`:
  - State codes, including ATUALIZA_PC = 4'b1000, which is also used by the PC incrementer.
  - Opcode constants.
  - funct3 constants for beq and bne.
  - `aluop` encodings.
- One sub-module, `gera_imediato`: purely combinational. Extracts the B-type offset and outputs its magnitude and sign, including the −4096 clamp.

## Test plan
- Reset, then release → `estado` sequence 0000, 0001 on consecutive cycles; all outputs 0 during reset.
- beq with offset −8 and `zero`=1 → in ATUALIZA_PC, `pcsrc`=1, `negativo`=1, `immediate`=12'd8; entered 3 cycles after BUSCA.
- beq with offset +16 and `zero`=0 → `pcsrc`=0, `immediate`=12'd16, `negativo`=0.
- Load with `mem_pronto` held low for 3 cycles → MEMORIA lasts 4 cycles, `memread`=1 throughout; ESCRITA follows with `regwrite`=`memtoreg`=1; total 9 cycles.
- Opcode 1111111 → `ilegal` pulses in DECODIFICA, next state is 1000 with `pcsrc`=0; then bne with `SUPORTE_BNE_EN` undefined → `ilegal` pulse in EXECUTA.
- `rst` asserted during MEMORIA of a store → next `estado`=0000, `memwrite` drops to 0, ATUALIZA_PC never occurs.

Source files
------------

// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle RISC-V control unit.
// State codes, opcodes, branch funct3 values and aluop encodings.
package controle_pkg;

    typedef enum logic [3:0] {
        BUSCA       = 4'b0000,
        DECODIFICA  = 4'b0001,
        EXECUTA     = 4'b0010,
        MEMORIA     = 4'b0011,
        ESCRITA     = 4'b0100,
        ATUALIZA_PC = 4'b1000
    } estado_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic opcode_valido(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Bundle between the control FSM (master) and the datapath (slave).
// Carries instrucao/zero/mem_pronto in, state, PC-update and enables out.
interface controle_multiciclo_if #(
    parameter int LARGURA_INSTR = 32
);
    logic [LARGURA_INSTR-1:0] instrucao;
    logic                     zero;
    logic                     mem_pronto;
    logic [3:0]               estado;
    logic                     pcsrc;
    logic [11:0]              immediate;
    logic                     negativo;
    logic                     regwrite;
    logic                     memread;
    logic                     memwrite;
    logic                     alusrc;
    logic                     memtoreg;
    logic [1:0]               aluop;
    logic                     ilegal;

    modport master (
        input  instrucao, zero, mem_pronto,
        output estado, pcsrc, immediate, negativo,
        output regwrite, memread, memwrite, alusrc, memtoreg,
        output aluop, ilegal
    );

    modport slave (
        output instrucao, zero, mem_pronto,
        input  estado, pcsrc, immediate, negativo,
        input  regwrite, memread, memwrite, alusrc, memtoreg,
        input  aluop, ilegal
    );
endinterface

// File: rtl/gera_imediato.sv
// Combinational B-type offset extractor: magnitude and sign outputs.
// Ports: campo_alto=inst[31:25], campo_baixo=inst[11:7] -> immediate, negativo.
module gera_imediato (
    input  logic [6:0]  campo_alto,
    input  logic [4:0]  campo_baixo,
    output logic [11:0] immediate,
    output logic        negativo
);
    logic [12:0] offset;
    logic [11:0] magnitude;

    assign offset = {campo_alto[6], campo_baixo[0], campo_alto[5:0],
                     campo_baixo[4:1], 1'b0};

    // Lower 12 bits of the negation are exact for every offset but -4096.
    assign magnitude = offset[12] ? (~offset[11:0] + 12'd1) : offset[11:0];

    always_comb begin
        negativo  = offset[12];
        immediate = magnitude;
        if (offset == 13'h1000)
            immediate = 12'hFFC;
    end
endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM: BUSCA/DECODIFICA/EXECUTA/MEMORIA/ESCRITA/ATUALIZA_PC.
// Ports: clk, rst (sync, active-high), bus (master). Macro: SUPORTE_BNE_EN.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int LARGURA_INSTR = 32
) (
    input logic                  clk,
    input logic                  rst,
    controle_multiciclo_if.master bus
);
    estado_t                  state;
    estado_t                  next;
    logic [LARGURA_INSTR-1:0] instr_q;
    logic                     pcsrc_r;
    logic [11:0]              imm_r;
    logic                     neg_r;
    logic [11:0]              imm_calc;
    logic                     neg_calc;
    logic [6:0]               op;
    logic [2:0]               f3;
    logic                     is_load;
    logic                     branch_ok;
    logic                     taken;
    logic                     ilegal;
    logic                     unused;

    assign op      = instr_q[6:0];
    assign f3      = instr_q[14:12];
    assign is_load = (op == OP_LOAD);
    assign unused  = ^instr_q[24:15];

`ifdef SUPORTE_BNE_EN
    assign branch_ok = (f3 == F3_BEQ) || (f3 == F3_BNE);
`else
    assign branch_ok = (f3 == F3_BEQ);
`endif

    assign taken = (f3 == F3_BEQ) ? bus.zero : !bus.zero;

    gera_imediato u_imm (
        .campo_alto  (instr_q[31:25]),
        .campo_baixo (instr_q[11:7]),
        .immediate   (imm_calc),
        .negativo    (neg_calc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BUSCA;
            instr_q <= '0;
            pcsrc_r <= 1'b0;
            imm_r   <= '0;
            neg_r   <= 1'b0;
        end else begin
            state <= next;
            if (state == BUSCA)
                instr_q <= bus.instrucao;
            if (state == EXECUTA && op == OP_BRANCH && branch_ok) begin
                pcsrc_r <= taken;
                imm_r   <= imm_calc;
                neg_r   <= neg_calc;
            end else if (state == ATUALIZA_PC || ilegal) begin
                // Illegal instructions leave as a NOP; ATUALIZA_PC exit clears.
                pcsrc_r <= 1'b0;
                imm_r   <= '0;
                neg_r   <= 1'b0;
            end
        end
    end

    always_comb begin
        next         = state;
        ilegal       = 1'b0;
        bus.regwrite = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.alusrc   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.aluop    = ALUOP_ADD;
        unique case (state)
            BUSCA: next = DECODIFICA;
            DECODIFICA: begin
                if (opcode_valido(op)) begin
                    next = EXECUTA;
                end else begin
                    next   = ATUALIZA_PC;
                    ilegal = 1'b1;
                end
            end
            EXECUTA: begin
                if (op == OP_R || op == OP_I) begin
                    next       = ESCRITA;
                    bus.aluop  = ALUOP_FUNCT;
                    bus.alusrc = (op == OP_I);
                end else if (op == OP_LOAD || op == OP_STORE) begin
                    next       = MEMORIA;
                    bus.aluop  = ALUOP_ADD;
                    bus.alusrc = 1'b1;
                end else begin
                    next      = ATUALIZA_PC;
                    bus.aluop = ALUOP_SUB;
                    ilegal    = !branch_ok;
                end
            end
            MEMORIA: begin
                bus.memread  = is_load;
                bus.memwrite = !is_load;
                if (bus.mem_pronto)
                    next = is_load ? ESCRITA : ATUALIZA_PC;
            end
            ESCRITA: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = is_load;
                next         = ATUALIZA_PC;
            end
            ATUALIZA_PC: next = BUSCA;
            default:     next = BUSCA;
        endcase
    end

    assign bus.estado    = state;
    assign bus.pcsrc     = pcsrc_r;
    assign bus.immediate = imm_r;
    assign bus.negativo  = neg_r;
    assign bus.ilegal    = ilegal;
endmodule
